// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter (LSB first, gapless frames); tx falls one cycle after a write into an empty idle FIFO.
// Writes while full are dropped with a one-cycle overflow pulse; define UART_TX_PARITY_EN to append an even parity bit.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 104,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [DATA_BITS-1:0]        wr_data,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic                        busy,
  output logic                        tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
  localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 push, pop;
  logic [LW-1:0]        level_nxt;
  logic [DATA_BITS-1:0] head;

  state_t               state, state_nxt;
  logic [BW-1:0]        baud_cnt, baud_nxt;
  logic [CW-1:0]        bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shreg, sh_nxt;
  logic                 tx_nxt;
  logic                 baud_end;

`ifdef UART_TX_PARITY_EN
  logic                 parity, parity_nxt;
`endif

  // full is the registered flag, so a pop on the same edge cannot free a slot for this write
  assign push = wr_en && !full;
  assign head = mem[rd_ptr];
  assign busy = (state != IDLE);
  assign baud_end = (baud_cnt == BAUD_LAST);

  always_comb begin
    level_nxt = level;
    if (push && !pop)
      level_nxt = level + LW'(1);
    else if (pop && !push)
      level_nxt = level - LW'(1);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      level    <= level_nxt;
      full     <= (level_nxt == DEPTH_L);
      overflow <= wr_en && full;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shreg    <= sh_nxt;
      tx       <= tx_nxt;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)
      parity <= 1'b0;
    else
      parity <= parity_nxt;
  end
`endif

  // tx is registered from the next state, so each bit appears on the edge that enters it
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    sh_nxt    = shreg;
    tx_nxt    = tx;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_nxt = parity;
`endif
    case (state)
      IDLE: begin
        tx_nxt   = 1'b1;
        baud_nxt = '0;
        if (level != '0) begin
          pop       = 1'b1;
          sh_nxt    = head;
          bit_nxt   = '0;
          tx_nxt    = 1'b0;
          state_nxt = START;
`ifdef UART_TX_PARITY_EN
          parity_nxt = ^head;
`endif
        end
      end
      START: begin
        if (baud_end) begin
          baud_nxt  = '0;
          tx_nxt    = shreg[0];
          state_nxt = DATA;
        end else begin
          baud_nxt = baud_cnt + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_nxt = '0;
          sh_nxt   = shreg >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
            tx_nxt    = parity;
            state_nxt = PARITY;
`else
            tx_nxt    = 1'b1;
            state_nxt = STOP;
`endif
          end else begin
            bit_nxt = bit_cnt + CW'(1);
            tx_nxt  = shreg[1];
          end
        end else begin
          baud_nxt = baud_cnt + BW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          baud_nxt  = '0;
          tx_nxt    = 1'b1;
          state_nxt = STOP;
        end else begin
          baud_nxt = baud_cnt + BW'(1);
        end
      end
`endif
      STOP: begin
        if (baud_end) begin
          baud_nxt = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_nxt = '0;
            if (level != '0) begin
              pop       = 1'b1;
              sh_nxt    = head;
              tx_nxt    = 1'b0;
              state_nxt = START;
`ifdef UART_TX_PARITY_EN
              parity_nxt = ^head;
`endif
            end else begin
              tx_nxt    = 1'b1;
              state_nxt = IDLE;
            end
          end else begin
            bit_nxt = bit_cnt + CW'(1);
          end
        end else begin
          baud_nxt = baud_cnt + BW'(1);
        end
      end
      default: begin
        tx_nxt    = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: 8N1 instance with a frame scoreboard, plus a 7-bit two-stop-bit instance.
module tb_uart_tx_fifo;
  localparam int CD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FLEN_A = (1 + 8 + P + 1) * CD;
  localparam int FLEN_B = (1 + 7 + P + 2) * CD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en_a = 1'b0;
  logic [7:0] wr_data_a = '0;
  logic       full_a, ovf_a, busy_a, tx_a;
  logic [2:0] level_a;
  logic       wr_en_b = 1'b0;
  logic [6:0] wr_data_b = '0;
  logic       full_b, ovf_b, busy_b, tx_b;
  logic [2:0] level_b;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_DIV(CD), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .sys_clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_data(wr_data_a), .full(full_a),
    .level(level_a), .overflow(ovf_a), .busy(busy_a), .tx(tx_a));

  uart_tx_fifo #(.CLK_DIV(CD), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .sys_clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_data(wr_data_b), .full(full_b),
    .level(level_b), .overflow(ovf_b), .busy(busy_b), .tx(tx_b));

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  int         gaps_q[$];
  int         frames_a = 0;
  int         cyc = 0;
  int         last_end = -100;
  logic       samp [FLEN_A];
  int         mon_n = 0;
  bit         mon_act = 1'b0;
  logic       last_par = 1'b0;
  logic [7:0] m_exp, m_got;
  logic       m_bit;
  bit         m_ok;

  // Frame monitor on dut_a: collects one frame of per-cycle samples, then checks it against the scoreboard
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (tx_a === 1'b0) begin
        mon_act = 1'b1;
        samp[0] = tx_a;
        mon_n = 1;
        gaps_q.push_back(cyc - last_end - 1);
      end
    end else begin
      samp[mon_n] = tx_a;
      mon_n++;
      if (mon_n == FLEN_A) begin
        mon_act = 1'b0;
        last_end = cyc;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL frame_a: frame seen with no word queued");
        end else begin
          m_exp = exp_q.pop_front();
          m_ok = 1'b1;
          for (int c = 0; c < FLEN_A; c++) begin
            if (c / CD == 0)
              m_bit = 1'b0;
            else if (c / CD <= 8)
              m_bit = m_exp[c / CD - 1];
            else if (P == 1 && c / CD == 9)
              m_bit = ^m_exp;
            else
              m_bit = 1'b1;
            if (samp[c] !== m_bit)
              m_ok = 1'b0;
          end
          for (int i = 0; i < 8; i++)
            m_got[i] = samp[(i + 1) * CD + CD / 2];
          if (!m_ok) begin
            fails++;
            $display("FAIL frame_a: decoded %h, required %h with %0d-cycle bits", m_got, m_exp, CD);
          end
        end
        last_par = samp[9 * CD + CD / 2];
        frames_a++;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++; if (tx_a !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b, required 1", tx_a); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", busy_a); end
    tests++; if (full_a !== 1'b0) begin fails++; $display("FAIL reset_full: got %b, required 0", full_a); end
    tests++; if (level_a !== 3'd0) begin fails++; $display("FAIL reset_level: got %0d, required 0", level_a); end
    tests++; if (ovf_a !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b, required 0", ovf_a); end
    tests++; if (tx_b !== 1'b1) begin fails++; $display("FAIL reset_tx_b: got %b, required 1", tx_b); end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
      fails++; $display("FAIL reset_release: tx %b busy %b, required 1 0", tx_a, busy_a);
    end
  endtask

  task automatic test_single_frame();
    int n;
    int t0;
    t0 = frames_a;
    @(negedge clk);
    wr_en_a = 1'b1; wr_data_a = 8'h33; exp_q.push_back(8'h33);
    @(negedge clk);
    wr_en_a = 1'b0;
    tests++;
    if (level_a !== 3'd1 || tx_a !== 1'b1 || busy_a !== 1'b0) begin
      fails++; $display("FAIL single_write_edge: level %0d tx %b busy %b, required 1 1 0", level_a, tx_a, busy_a);
    end
    @(negedge clk);
    tests++;
    if (tx_a !== 1'b0 || level_a !== 3'd0 || busy_a !== 1'b1) begin
      fails++; $display("FAIL single_pop_edge: tx %b level %0d busy %b, required 0 0 1", tx_a, level_a, busy_a);
    end
    n = 0;
    while (busy_a === 1'b1 && n < 200) begin n++; @(negedge clk); end
    tests++;
    if (n != FLEN_A) begin fails++; $display("FAIL single_busy_len: got %0d cycles, required %0d", n, FLEN_A); end
    tests++;
    if (level_a !== 3'd0 || tx_a !== 1'b1 || frames_a != t0 + 1) begin
      fails++; $display("FAIL single_end: level %0d tx %b frames %0d, required 0 1 %0d", level_a, tx_a, frames_a - t0, 1);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int t0;
    int peak;
    logic [7:0] words [3];
    words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
    t0 = frames_a;
    peak = 0;
    gaps_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (int'(level_a) > peak) peak = int'(level_a);
      wr_en_a = 1'b1; wr_data_a = words[i]; exp_q.push_back(words[i]);
    end
    @(negedge clk);
    wr_en_a = 1'b0;
    n = 0;
    while (frames_a < t0 + 3 && n < 400) begin
      if (int'(level_a) > peak) peak = int'(level_a);
      n++; @(negedge clk);
    end
    tests++;
    if (peak != 2) begin fails++; $display("FAIL burst_level_peak: got %0d, required 2", peak); end
    tests++;
    if (frames_a != t0 + 3) begin fails++; $display("FAIL burst_frames: got %0d, required 3", frames_a - t0); end
    tests++;
    if (gaps_q.size() != 3 || gaps_q[1] != 0 || gaps_q[2] != 0) begin
      fails++; $display("FAIL burst_gapless: %0d frames, gaps %0d %0d, required 3 frames, gaps 0 0",
                        gaps_q.size(), gaps_q.size() > 1 ? gaps_q[1] : -1, gaps_q.size() > 2 ? gaps_q[2] : -1);
    end
    n = 0;
    while (busy_a === 1'b1 && n < 50) begin n++; @(negedge clk); end
  endtask

  task automatic test_overflow();
    int n;
    int t0;
    t0 = frames_a;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) begin
        tests++;
        if (full_a !== 1'b1 || ovf_a !== 1'b0) begin
          fails++; $display("FAIL ovf_full_after_5: full %b overflow %b, required 1 0", full_a, ovf_a);
        end
      end
      wr_en_a = 1'b1; wr_data_a = 8'hA0 + 8'(i);
      if (i < 5) exp_q.push_back(8'hA0 + 8'(i));
    end
    @(negedge clk);
    wr_en_a = 1'b0;
    tests++;
    if (ovf_a !== 1'b1 || full_a !== 1'b1) begin
      fails++; $display("FAIL ovf_pulse: overflow %b full %b, required 1 1", ovf_a, full_a);
    end
    @(negedge clk);
    tests++;
    if (ovf_a !== 1'b0) begin fails++; $display("FAIL ovf_one_cycle: got %b, required 0", ovf_a); end
    n = 0;
    while (frames_a < t0 + 5 && n < 600) begin n++; @(negedge clk); end
    repeat (100) @(negedge clk);
    tests++;
    if (frames_a != t0 + 5 || exp_q.size() != 0 || busy_a !== 1'b0) begin
      fails++; $display("FAIL ovf_frames: got %0d frames, %0d pending, busy %b, required 5 0 0",
                        frames_a - t0, exp_q.size(), busy_a);
    end
  endtask

  task automatic test_parity();
    int n;
    int t0;
    logic par1, par2, exp1, exp2;
    t0 = frames_a;
    gaps_q.delete();
    @(negedge clk);
    wr_en_a = 1'b1; wr_data_a = 8'h33; exp_q.push_back(8'h33);
    @(negedge clk);
    wr_data_a = 8'h07; exp_q.push_back(8'h07);
    @(negedge clk);
    wr_en_a = 1'b0;
    n = 0;
    while (frames_a < t0 + 1 && n < 200) begin n++; @(negedge clk); end
    par1 = last_par;
    n = 0;
    while (frames_a < t0 + 2 && n < 200) begin n++; @(negedge clk); end
    par2 = last_par;
`ifdef UART_TX_PARITY_EN
    exp1 = 1'b0; exp2 = 1'b1;
`else
    exp1 = 1'b1; exp2 = 1'b1;
`endif
    tests++;
    if (par1 !== exp1) begin fails++; $display("FAIL parity_0x33: bit 9 got %b, required %b", par1, exp1); end
    tests++;
    if (par2 !== exp2) begin fails++; $display("FAIL parity_0x07: bit 9 got %b, required %b", par2, exp2); end
    tests++;
    if (frames_a != t0 + 2 || gaps_q.size() != 2 || gaps_q[1] != 0) begin
      fails++; $display("FAIL parity_frames: got %0d frames, %0d starts, required 2 gapless", frames_a - t0, gaps_q.size());
    end
    n = 0;
    while (busy_a === 1'b1 && n < 50) begin n++; @(negedge clk); end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    int t0;
    bit activity;
    t0 = frames_a;
    @(negedge clk);
    wr_en_a = 1'b1; wr_data_a = 8'h11; exp_q.push_back(8'h11);
    @(negedge clk);
    wr_data_a = 8'h22;
    @(negedge clk);
    wr_data_a = 8'h44;
    @(negedge clk);
    wr_en_a = 1'b0;
    n = 0;
    while (frames_a < t0 + 1 && n < 200) begin n++; @(negedge clk); end
    repeat (CD * 3) @(negedge clk);
    tests++;
    if (busy_a !== 1'b1 || level_a !== 3'd1 || tx_a !== 1'b0) begin
      fails++; $display("FAIL rstmid_pre: busy %b level %0d tx %b, required 1 1 0", busy_a, level_a, tx_a);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (tx_a !== 1'b1 || level_a !== 3'd0 || busy_a !== 1'b0) begin
      fails++; $display("FAIL rstmid_async: tx %b level %0d busy %b, required 1 0 0", tx_a, level_a, busy_a);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    activity = 1'b0;
    for (int i = 0; i < 100; i++) begin
      wr_data_a = 8'($urandom);
      @(negedge clk);
      if (busy_a !== 1'b0 || tx_a !== 1'b1) activity = 1'b1;
    end
    tests++;
    if (activity || frames_a != t0 + 1) begin
      fails++; $display("FAIL rstmid_quiet: activity %b frames %0d, required 0 1", activity, frames_a - t0);
    end
    @(negedge clk);
    wr_en_a = 1'b1; wr_data_a = 8'h5A; exp_q.push_back(8'h5A);
    @(negedge clk);
    wr_en_a = 1'b0;
    n = 0;
    while (frames_a < t0 + 2 && n < 200) begin n++; @(negedge clk); end
    tests++;
    if (frames_a != t0 + 2 || exp_q.size() != 0) begin
      fails++; $display("FAIL rstmid_new_write: frames %0d pending %0d, required 2 0", frames_a - t0, exp_q.size());
    end
    n = 0;
    while (busy_a === 1'b1 && n < 50) begin n++; @(negedge clk); end
  endtask

  task automatic test_stop2_7bit();
    logic [6:0] d;
    logic       b;
    int         bad;
    d = 7'h55;
    bad = 0;
    @(negedge clk);
    wr_en_b = 1'b1; wr_data_b = d;
    @(negedge clk);
    wr_en_b = 1'b0;
    @(negedge clk);
    tests++;
    if (busy_b !== 1'b1 || tx_b !== 1'b0) begin
      fails++; $display("FAIL stop2_start: busy %b tx %b, required 1 0", busy_b, tx_b);
    end
    for (int c = 0; c < FLEN_B; c++) begin
      if (c / CD == 0)
        b = 1'b0;
      else if (c / CD <= 7)
        b = d[c / CD - 1];
      else if (P == 1 && c / CD == 8)
        b = ^d;
      else
        b = 1'b1;
      if (tx_b !== b) bad++;
      @(negedge clk);
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL stop2_pattern: %0d wrong cycles, required 0", bad); end
    tests++;
    if (busy_b !== 1'b0 || tx_b !== 1'b1 || level_b !== 3'd0) begin
      fails++; $display("FAIL stop2_end: busy %b tx %b level %0d, required 0 1 0", busy_b, tx_b, level_b);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_parity();
    test_reset_mid_frame();
    test_stop2_7bit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
